pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen.sv | 143 ++++++++++++++
 tb/tb_pc_gen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Program counter generator: boot hold, sequential step, trap/branch
// redirects with a pending slot for redirects that arrive while fetch is held.
module pc_gen #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_ADDR = '0,
    parameter bit              C_EXT      = 1'b0,
    parameter bit              BOOT_WAIT  = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_stall,
    input  logic            i_writing_first_addr,
    input  logic [XLEN-1:0] i_instr_start_addr,
    input  logic            i_trap,
    input  logic [XLEN-1:0] i_trap_vec,
    input  logic            i_is_branch_true,
    input  logic [XLEN-1:0] i_branch_addr,
    input  logic            i_instr_compressed,
    input  logic            i_fetch_ready,
    output logic            o_fetch_valid,
    output logic [XLEN-1:0] o_r_pc,
    output logic            o_misalign_exc,
    output logic [XLEN-1:0] o_misalign_addr
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    localparam logic [XLEN-1:0] ALIGN_MASK = C_EXT ? XLEN'(1) : XLEN'(3);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pend_valid_q, pend_valid_d;
    logic            pend_is_trap_q, pend_is_trap_d;
    logic [XLEN-1:0] pend_addr_q, pend_addr_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;

    logic            run;
    logic            advance;
    logic [XLEN-1:0] step;
    logic [XLEN-1:0] trap_tgt;
    logic            br_misaligned;
    logic            live_trap;
    logic            live_br;
    logic            bad_br;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= BOOT_WAIT ? S_IDLE : S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_writing_first_addr) state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_fetch_valid = (state_q == S_RUN);
    end

    // Writing a start address outranks everything, so it masks redirects.
    always_comb begin
        run           = (state_q == S_RUN);
        advance       = run & i_fetch_ready & ~i_stall;
        step          = (C_EXT && i_instr_compressed) ? XLEN'(2) : XLEN'(4);
        trap_tgt      = i_trap_vec & ~ALIGN_MASK;
        br_misaligned = |(i_branch_addr & ALIGN_MASK);
        live_trap     = run & ~i_writing_first_addr & i_trap;
        live_br       = run & ~i_writing_first_addr & ~i_trap
                        & i_is_branch_true & ~br_misaligned;
        bad_br        = run & ~i_writing_first_addr & ~i_trap
                        & i_is_branch_true & br_misaligned;
    end

    always_comb begin
        pc_d            = pc_q;
        pend_valid_d    = pend_valid_q;
        pend_is_trap_d  = pend_is_trap_q;
        pend_addr_d     = pend_addr_q;
        misalign_d      = bad_br;
        misalign_addr_d = bad_br ? i_branch_addr : misalign_addr_q;
        if (i_writing_first_addr) begin
            pc_d         = i_instr_start_addr;
            pend_valid_d = 1'b0;
        end else if (advance) begin
            if (live_trap) begin
                pc_d         = trap_tgt;
                pend_valid_d = 1'b0;
            end else if (live_br) begin
                pc_d         = i_branch_addr;
                pend_valid_d = 1'b0;
            end else if (bad_br) begin
                pc_d = pc_q;
            end else if (pend_valid_q) begin
                pc_d         = pend_addr_q;
                pend_valid_d = 1'b0;
            end else begin
                pc_d = pc_q + step;
            end
        end else if (live_trap) begin
            pend_valid_d   = 1'b1;
            pend_is_trap_d = 1'b1;
            pend_addr_d    = trap_tgt;
        end else if (live_br && !(pend_valid_q && pend_is_trap_q)) begin
            pend_valid_d   = 1'b1;
            pend_is_trap_d = 1'b0;
            pend_addr_d    = i_branch_addr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pc_q            <= RESET_ADDR;
            pend_valid_q    <= 1'b0;
            pend_is_trap_q  <= 1'b0;
            pend_addr_q     <= '0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            pc_q            <= pc_d;
            pend_valid_q    <= pend_valid_d;
            pend_is_trap_q  <= pend_is_trap_d;
            pend_addr_q     <= pend_addr_d;
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
        end
    end

    assign o_r_pc          = pc_q;
    assign o_misalign_exc  = misalign_q;
    assign o_misalign_addr = misalign_addr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: a word-aligned boot-wait instance and a
// compressed-capable free-running instance, each with its own queues.
module tb_pc_gen;

    typedef struct packed {
        logic        stall;
        logic        wfa;
        logic [31:0] start;
        logic        trap;
        logic [31:0] tvec;
        logic        br;
        logic [31:0] baddr;
        logic        comp;
        logic        ready;
    } in_t;

    logic        clk;
    logic        rst_n;
    in_t         in0, in1;
    logic        fv0, fv1, exc0, exc1;
    logic [31:0] pc0, pc1, maddr0, maddr1;

    logic [31:0] q0[$], q1[$], m0[$], m1[$];
    int          checks = 0;
    int          errors = 0;

    pc_gen #(.XLEN(32), .RESET_ADDR(32'h0), .C_EXT(1'b0), .BOOT_WAIT(1'b1)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(in0.stall),
        .i_writing_first_addr(in0.wfa), .i_instr_start_addr(in0.start),
        .i_trap(in0.trap), .i_trap_vec(in0.tvec),
        .i_is_branch_true(in0.br), .i_branch_addr(in0.baddr),
        .i_instr_compressed(in0.comp), .i_fetch_ready(in0.ready),
        .o_fetch_valid(fv0), .o_r_pc(pc0),
        .o_misalign_exc(exc0), .o_misalign_addr(maddr0)
    );

    pc_gen #(.XLEN(32), .RESET_ADDR(32'h10), .C_EXT(1'b1), .BOOT_WAIT(1'b0)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(in1.stall),
        .i_writing_first_addr(in1.wfa), .i_instr_start_addr(in1.start),
        .i_trap(in1.trap), .i_trap_vec(in1.tvec),
        .i_is_branch_true(in1.br), .i_branch_addr(in1.baddr),
        .i_instr_compressed(in1.comp), .i_fetch_ready(in1.ready),
        .o_fetch_valid(fv1), .o_r_pc(pc1),
        .o_misalign_exc(exc1), .o_misalign_addr(maddr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted fetch and every misalign pulse pops an entry.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fv0 && in0.ready && !in0.stall) begin
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dut0_fetch: got %h expected none", pc0);
                end else chk("dut0_fetch", pc0, q0.pop_front());
            end
            if (fv1 && in1.ready && !in1.stall) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dut1_fetch: got %h expected none", pc1);
                end else chk("dut1_fetch", pc1, q1.pop_front());
            end
            if (exc0) begin
                if (m0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dut0_misalign: got %h expected none", maddr0);
                end else chk("dut0_misalign", maddr0, m0.pop_front());
            end
            if (exc1) begin
                if (m1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dut1_misalign: got %h expected none", maddr1);
                end else chk("dut1_misalign", maddr1, m1.pop_front());
            end
        end
    end

    initial begin
        in0 = '0;
        in1 = '0;
        rst_n = 1'b0;
        tick; tick;
        chk("rst_pc0", pc0, 32'h0);
        chk("rst_fv0", {31'b0, fv0}, 32'h0);
        chk("rst_exc0", {31'b0, exc0}, 32'h0);
        chk("rst_maddr0", maddr0, 32'h0);
        chk("rst_pc1", pc1, 32'h10);
        chk("rst_fv1", {31'b0, fv1}, 32'h1);
        rst_n = 1'b1;

        // Idle ignores redirects and ready.
        in0.ready = 1; in0.trap = 1; in0.tvec = 32'h500;
        in0.br = 1; in0.baddr = 32'h600;
        tick; tick;
        chk("idle_fv0", {31'b0, fv0}, 32'h0);
        chk("idle_pc0", pc0, 32'h0);
        in0.trap = 0; in0.br = 0;
        in0.wfa = 1; in0.start = 32'h1000;
        tick;
        chk("load_fv0", {31'b0, fv0}, 32'h1);
        chk("load_pc0", pc0, 32'h1000);
        in0.wfa = 0;
        q0.push_back(32'h1000); tick;
        q0.push_back(32'h1004); tick;
        q0.push_back(32'h1008); tick;

        // Branch while stalled becomes pending.
        in0.wfa = 1; in0.start = 32'h2000; in0.stall = 1; tick;
        in0.wfa = 0; in0.br = 1; in0.baddr = 32'h3000; tick;
        in0.br = 0; tick; tick;
        chk("stall_pc0", pc0, 32'h2000);
        in0.stall = 0;
        q0.push_back(32'h2000); tick;
        q0.push_back(32'h3000); tick;

        // Pending trap overrides pending branch; later branch cannot.
        in0.stall = 1; in0.br = 1; in0.baddr = 32'h3100; tick;
        in0.br = 0; in0.trap = 1; in0.tvec = 32'h101; tick;
        in0.trap = 0; in0.br = 1; in0.baddr = 32'h3200; tick;
        in0.br = 0; in0.stall = 0;
        q0.push_back(32'h3004); tick;
        q0.push_back(32'h100); tick;

        // Misaligned branch holds the pc and pulses the exception.
        in0.br = 1; in0.baddr = 32'h202;
        q0.push_back(32'h104); m0.push_back(32'h202); tick;
        in0.br = 0;
        q0.push_back(32'h104); tick;
        chk("exc_pulse0", {31'b0, exc0}, 32'h0);
        in0.trap = 1; in0.tvec = 32'h403; in0.br = 1; in0.baddr = 32'h203;
        q0.push_back(32'h108); tick;
        in0.trap = 0; in0.br = 0;
        chk("trap_noexc0", {31'b0, exc0}, 32'h0);
        q0.push_back(32'h400); tick;

        // Wrap, with compressed ignored on this instance.
        in0.wfa = 1; in0.start = 32'hFFFF_FFFC;
        q0.push_back(32'h404); tick;
        in0.wfa = 0; in0.comp = 1;
        q0.push_back(32'hFFFF_FFFC); tick;
        q0.push_back(32'h0); tick;
        in0.comp = 0; in0.ready = 0; tick; tick;
        chk("noready_pc0", pc0, 32'h4);
        chk("noready_fv0", {31'b0, fv0}, 32'h1);

        // Start write in run clears pending and loads at once.
        in0.br = 1; in0.baddr = 32'h800; tick;
        in0.br = 0; in0.wfa = 1; in0.start = 32'h900; tick;
        chk("wfa_run_pc0", pc0, 32'h900);
        in0.wfa = 0; in0.ready = 1;
        q0.push_back(32'h900); tick;
        q0.push_back(32'h904); tick;

        // Reset with a pending branch during stall.
        in0.stall = 1; in0.br = 1; in0.baddr = 32'hA00; tick;
        in0.br = 0; rst_n = 1'b0; tick;
        chk("rst2_pc0", pc0, 32'h0);
        chk("rst2_fv0", {31'b0, fv0}, 32'h0);
        chk("rst2_pc1", pc1, 32'h10);
        rst_n = 1'b1; in0.stall = 0; tick;
        in0.wfa = 1; in0.start = 32'h40; tick;
        in0.wfa = 0;
        q0.push_back(32'h40); tick;
        q0.push_back(32'h44); tick;
        in0.ready = 0;

        // Compressed-capable instance.
        in1.ready = 1; in1.comp = 1;
        q1.push_back(32'h10); tick;
        in1.br = 1; in1.baddr = 32'h15;
        q1.push_back(32'h12); m1.push_back(32'h15); tick;
        in1.br = 0; in1.comp = 0;
        q1.push_back(32'h12); tick;
        chk("exc_pulse1", {31'b0, exc1}, 32'h0);
        q1.push_back(32'h16); tick;
        in1.trap = 1; in1.tvec = 32'h103;
        q1.push_back(32'h1A); tick;
        in1.trap = 0; in1.br = 1; in1.baddr = 32'h206;
        q1.push_back(32'h102); tick;
        in1.br = 0; in1.comp = 1;
        q1.push_back(32'h206); tick;
        q1.push_back(32'h208); tick;
        in1.ready = 0; in1.comp = 0;
        tick; tick;
        chk("final_pc1", pc1, 32'h20A);
        chk("final_pc0", pc0, 32'h48);
        chk("q0_empty", q0.size(), 32'h0);
        chk("q1_empty", q1.size(), 32'h0);
        chk("m0_empty", m0.size(), 32'h0);
        chk("m1_empty", m1.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
